// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM state and the externally visible status code.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } run_state_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, one-cycle update, synchronous clear wins over enable; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles/retirements, ends the test on tohost or watchdog.
// All outputs registered (one-edge response); no backpressure, terminal states hold until rst_n.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 5,
    parameter int              MAX_CYCLES  = 200,
    parameter int              STALL_LIMIT = 64,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_1000)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             core_rst,
    input  logic             retire_valid,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic [1:0]       status,
    output logic             stall_to,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STALL_LAST  = CNT_W'(STALL_LIMIT - 1);

    run_state_e        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              in_hold;
    logic              in_run;
    logic              tohost_hit;
    logic              stall_hit;
    logic              budget_hit;

    assign in_hold = (state == HOLD);
    assign in_run  = (state == RUN);

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk(clk), .rst_n(rst_n), .en(in_hold), .clr(1'b0), .cnt(hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_n(rst_n), .en(in_run), .clr(1'b0), .cnt(cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk(clk), .rst_n(rst_n), .en(in_run && retire_valid), .clr(1'b0), .cnt(retire_count)
    );

    // Counts consecutive RUN cycles without a retirement.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .en(in_run && !retire_valid), .clr(in_run && retire_valid),
        .cnt(stall_cnt)
    );

    assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
    assign stall_hit  = (STALL_LIMIT != 0) && !retire_valid && (stall_cnt == STALL_LAST);
    assign budget_hit = (MAX_CYCLES != 0) && (cycle_count == BUDGET_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HOLD;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            status    <= ST_RUN;
            stall_to  <= 1'b0;
            fail_code <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                    end
                end
                RUN: begin
                    // tohost beats the stall watchdog, which beats the cycle budget.
                    if (tohost_hit) begin
                        core_rst <= 1'b1;
                        done     <= 1'b1;
                        if (st_data == XLEN'(1)) begin
                            state  <= PASS;
                            status <= ST_PASS;
                        end else begin
                            state     <= FAIL;
                            status    <= ST_FAIL;
                            fail_code <= st_data >> 1;
                        end
                    end else if (stall_hit || budget_hit) begin
                        state    <= TIMEOUT;
                        status   <= ST_TIMEOUT;
                        stall_to <= stall_hit;
                        core_rst <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: per-scenario expectations from a cycle-level reference model.
module tb_sim_run_ctrl;

    localparam int XLEN        = 32;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 5;
    localparam int MAX_CYCLES  = 200;
    localparam int STALL_LIMIT = 64;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam int NC = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             retire_valid = 1'b0;
    logic             st_valid = 1'b0;
    logic [XLEN-1:0]  st_addr = '0;
    logic [XLEN-1:0]  st_data = '0;
    logic             core_rst;
    logic             done;
    logic [1:0]       status;
    logic             stall_to;
    logic [XLEN-1:0]  fail_code;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          status;
        bit          stall_to;
        logic [31:0] fail_code;
        int          cyc;
        int          ret;
    } exp_t;

    exp_t exp_q[$];

    bit          ret_a[NC];
    bit          sv_a[NC];
    logic [31:0] sa_a[NC];
    logic [31:0] sd_a[NC];

    sim_run_ctrl #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
        .STALL_LIMIT(STALL_LIMIT), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .core_rst(core_rst), .retire_valid(retire_valid),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .done(done),
        .status(status), .stall_to(stall_to), .fail_code(fail_code),
        .cycle_count(cycle_count), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Walks the scenario one RUN cycle at a time applying the end-of-test rules.
    function automatic exp_t model();
        exp_t e;
        int   retired;
        int   idle;
        bit   th;
        e = '{status: 0, stall_to: 0, fail_code: 0, cyc: 0, ret: 0};
        retired = 0;
        idle = 0;
        for (int k = 0; k < NC; k++) begin
            th = sv_a[k] && (sa_a[k] == TOHOST) && (sd_a[k] != 0);
            if (ret_a[k]) retired++;
            e.cyc = k + 1;
            e.ret = retired;
            if (th) begin
                e.status = (sd_a[k] == 1) ? 1 : 2;
                e.fail_code = (sd_a[k] == 1) ? 32'd0 : (sd_a[k] >> 1);
                return e;
            end
            if (!ret_a[k] && idle == STALL_LIMIT - 1) begin
                e.status = 3;
                e.stall_to = 1'b1;
                return e;
            end
            if (k == MAX_CYCLES - 1) begin
                e.status = 3;
                return e;
            end
            idle = ret_a[k] ? 0 : idle + 1;
        end
        return e;
    endfunction

    // Monitor: pops one expectation when done rises, then checks the outputs stay frozen.
    exp_t cur;
    bit   have = 1'b0;
    bit   seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || !done) begin
            seen = 1'b0;
            have = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: status=%0d cycle_count=%0d with nothing queued",
                         status, cycle_count);
            end else begin
                cur = exp_q.pop_front();
                have = 1'b1;
                chk("status", status, cur.status);
                chk("stall_to", stall_to, cur.stall_to);
                chk("fail_code", fail_code, cur.fail_code);
                chk("cycle_count", cycle_count, cur.cyc);
                chk("retire_count", retire_count, cur.ret);
                chk("core_rst_frozen", core_rst, 1);
            end
        end else if (have) begin
            chk("sticky_status", status, cur.status);
            chk("sticky_cycle", cycle_count, cur.cyc);
            chk("sticky_retire", retire_count, cur.ret);
            chk("sticky_core_rst", core_rst, 1);
        end
    end

    task automatic clear_pat();
        for (int k = 0; k < NC; k++) begin
            ret_a[k] = 1'b0;
            sv_a[k] = 1'b0;
            sa_a[k] = '0;
            sd_a[k] = '0;
        end
    endtask

    task automatic put_store(input int k, input logic [31:0] a, input logic [31:0] d);
        sv_a[k] = 1'b1;
        sa_a[k] = a;
        sd_a[k] = d;
    endtask

    task automatic run_scen(input int abort_at);
        // Asynchronous reset asserted away from a clock edge, from whatever state we are in.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_stall_to", stall_to, 0);
        chk("rst_fail_code", fail_code, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_retire", retire_count, 0);
        // Activity during reset and HOLD must be ignored.
        retire_valid = 1'b1;
        st_valid = 1'b1;
        st_addr = TOHOST;
        st_data = 32'd1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RST_CYCLES; i++) begin
            chk("hold_core_rst", core_rst, 1);
            chk("hold_status", status, 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("run_core_rst", core_rst, 0);
        chk("run_entry_cycle", cycle_count, 0);
        chk("run_entry_retire", retire_count, 0);
        chk("run_entry_done", done, 0);
        if (abort_at < 0) exp_q.push_back(model());
        for (int k = 0; k < NC && !done; k++) begin
            if (k == abort_at) begin
                chk("mid_run_status", status, 0);
                return;
            end
            retire_valid = ret_a[k];
            st_valid = sv_a[k];
            st_addr = sa_a[k];
            st_data = sd_a[k];
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done=%0d after %0d RUN cycles, required 1", done, NC);
        end
        // Terminal state must ignore further stores and retirements.
        for (int i = 0; i < 6; i++) begin
            retire_valid = 1'($urandom);
            st_valid = 1'b1;
            st_addr = TOHOST;
            st_data = $urandom_range(1, 3);
            @(negedge clk);
        end
        retire_valid = 1'b0;
        st_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        int s;
        int p;
        logic [31:0] d;

        // Pass: store 1 at RUN cycle 40 after 40 retirements.
        clear_pat();
        for (int k = 0; k < 40; k++) ret_a[k] = 1'b1;
        put_store(40, TOHOST, 32'd1);
        run_scen(-1);

        // Fail: a zero write first, then 7.
        clear_pat();
        for (int k = 0; k < NC; k++) ret_a[k] = 1'b1;
        put_store(20, TOHOST, 32'd0);
        put_store(25, TOHOST, 32'd7);
        run_scen(-1);

        // Budget with stores to a neighbouring address.
        clear_pat();
        for (int k = 0; k < NC; k++) ret_a[k] = 1'b1;
        put_store(50, TOHOST + 32'd4, 32'd1);
        put_store(90, TOHOST + 32'd8, 32'd5);
        run_scen(-1);

        // Stall after 10 retirements.
        clear_pat();
        for (int k = 0; k < 10; k++) ret_a[k] = 1'b1;
        run_scen(-1);

        // tohost on the same cycle as stall expiry.
        clear_pat();
        for (int k = 0; k < 10; k++) ret_a[k] = 1'b1;
        put_store(73, TOHOST, 32'd1);
        run_scen(-1);

        // Stall expiry on the same cycle as the budget.
        clear_pat();
        for (int k = 0; k < 136; k++) ret_a[k] = 1'b1;
        run_scen(-1);

        // Failing tohost on the last budget cycle.
        clear_pat();
        for (int k = 0; k < NC; k++) ret_a[k] = 1'b1;
        put_store(MAX_CYCLES - 1, TOHOST, 32'h0000_0105);
        run_scen(-1);

        // Abort mid-RUN; the next scenario re-runs the full sequence.
        clear_pat();
        for (int k = 0; k < NC; k++) ret_a[k] = 1'b1;
        run_scen(30);

        for (int n = 0; n < 12; n++) begin
            clear_pat();
            mode = $urandom_range(0, 3);
            p = $urandom_range(50, 100);
            s = $urandom_range(5, 180);
            for (int k = 0; k < NC; k++) begin
                ret_a[k] = ($urandom_range(1, 100) <= p);
                if ($urandom_range(0, 9) == 0)
                    put_store(k, TOHOST + 32'($urandom_range(1, 8)) * 32'd4, $urandom);
                else if ($urandom_range(0, 19) == 0)
                    put_store(k, TOHOST, 32'd0);
            end
            case (mode)
                0: put_store(s, TOHOST, 32'd1);
                1: begin
                    d = $urandom;
                    if (d < 2) d = d + 32'd2;
                    put_store(s, TOHOST, d);
                end
                3: for (int k = s; k < NC; k++) ret_a[k] = 1'b0;
                default: ;
            endcase
            run_scen(-1);
        end

        // Final reset pulse out of a terminal state.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("final_rst_done", done, 0);
        chk("final_rst_status", status, 0);
        chk("final_rst_core_rst", core_rst, 1);
        chk("queue_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
